// File: rtl/tcm_mem_arb_if.sv
// rtl/tcm_mem_arb_if.sv - fetch, data and external bus bundle for the TCM arbiter
// slave is the arbiter side; master is the requester side.
interface tcm_mem_arb_if;
    logic        mem_i_rd_i;
    logic [31:0] mem_i_pc_i;
    logic        mem_i_valid_o;
    logic        mem_i_error_o;
    logic [63:0] mem_i_inst_o;

    logic [31:0] mem_d_addr_i;
    logic [31:0] mem_d_data_wr_i;
    logic        mem_d_rd_i;
    logic [3:0]  mem_d_wr_i;
    logic        mem_d_cmo_i;
    logic [10:0] mem_d_req_tag_i;
    logic        mem_d_accept_o;
    logic        mem_d_ack_o;
    logic        mem_d_error_o;
    logic [31:0] mem_d_data_rd_o;
    logic [10:0] mem_d_resp_tag_o;

    logic        ext_rd_i;
    logic [3:0]  ext_wr_i;
    logic [31:0] ext_addr_i;
    logic [31:0] ext_data_wr_i;
    logic        ext_accept_o;
    logic        ext_ack_o;
    logic        ext_error_o;
    logic [31:0] ext_data_rd_o;

    modport slave (
        input  mem_i_rd_i, mem_i_pc_i,
        output mem_i_valid_o, mem_i_error_o, mem_i_inst_o,
        input  mem_d_addr_i, mem_d_data_wr_i, mem_d_rd_i, mem_d_wr_i, mem_d_cmo_i, mem_d_req_tag_i,
        output mem_d_accept_o, mem_d_ack_o, mem_d_error_o, mem_d_data_rd_o, mem_d_resp_tag_o,
        input  ext_rd_i, ext_wr_i, ext_addr_i, ext_data_wr_i,
        output ext_accept_o, ext_ack_o, ext_error_o, ext_data_rd_o
    );

    modport master (
        output mem_i_rd_i, mem_i_pc_i,
        input  mem_i_valid_o, mem_i_error_o, mem_i_inst_o,
        output mem_d_addr_i, mem_d_data_wr_i, mem_d_rd_i, mem_d_wr_i, mem_d_cmo_i, mem_d_req_tag_i,
        input  mem_d_accept_o, mem_d_ack_o, mem_d_error_o, mem_d_data_rd_o, mem_d_resp_tag_o,
        output ext_rd_i, ext_wr_i, ext_addr_i, ext_data_wr_i,
        input  ext_accept_o, ext_ack_o, ext_error_o, ext_data_rd_o
    );
endinterface

// File: rtl/tcm_mem_arb.sv
// rtl/tcm_mem_arb.sv - 64-bit TCM with read-only fetch port and data/external shared port
// Optional per-byte parity enabled by defining TCM_MEM_PARITY_EN.
module tcm_mem_arb #(
    parameter int TCM_MEM_DEPTH = 16,
    parameter int EXT_MAX_WAIT  = 4
) (
    input logic           clk_i,
    input logic           rst_i,
    tcm_mem_arb_if.slave  bus
);
    localparam int         WORDS    = TCM_MEM_DEPTH * 128;
    localparam int         AW       = $clog2(WORDS);
    localparam logic [3:0] MAX_WAIT = 4'(EXT_MAX_WAIT);

    logic [63:0] ram [WORDS];

    logic          data_req, ext_req, ext_grant, data_grant, data_fire;
    logic [3:0]    wait_cnt;
    logic [31:0]   sh_addr, sh_wdata;
    logic [3:0]    sh_be;
    logic [AW-1:0] sh_idx, i_idx;
    logic          sh_half;

    logic          i_valid_q, d_ack_q, e_ack_q, half_q;
    logic [10:0]   tag_q;
    logic [63:0]   inst_q, sh_rdata_q;
    logic [31:0]   rd_half;

    assign data_req   = bus.mem_d_rd_i | bus.mem_d_cmo_i | (|bus.mem_d_wr_i);
    assign ext_req    = bus.ext_rd_i | (|bus.ext_wr_i);
    assign ext_grant  = !rst_i && ext_req && (!data_req || wait_cnt == MAX_WAIT);
    assign data_grant = !rst_i && !ext_grant;
    assign data_fire  = data_grant && data_req;

    // One shared RAM port: the external requester wins it only on grant.
    always_comb begin
        sh_addr  = bus.mem_d_addr_i;
        sh_wdata = bus.mem_d_data_wr_i;
        sh_be    = 4'b0000;
        if (ext_grant) begin
            sh_addr  = bus.ext_addr_i;
            sh_wdata = bus.ext_data_wr_i;
            sh_be    = bus.ext_wr_i;
        end else if (data_fire && !bus.mem_d_cmo_i) begin
            sh_be    = bus.mem_d_wr_i;
        end
    end

    assign sh_idx  = sh_addr[AW+2:3];
    assign sh_half = sh_addr[2];
    assign i_idx   = bus.mem_i_pc_i[AW+2:3];

    // Non-blocking reads give read-first behaviour against a same-cycle write.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 4; b++) begin
            if (sh_be[b]) begin
                if (sh_half) ram[sh_idx][32 + 8*b +: 8] <= sh_wdata[8*b +: 8];
                else         ram[sh_idx][8*b +: 8]      <= sh_wdata[8*b +: 8];
            end
        end
        if (bus.mem_i_rd_i)
            inst_q <= ram[i_idx];
        if (data_fire || ext_grant)
            sh_rdata_q <= ram[sh_idx];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            i_valid_q <= 1'b0;
            d_ack_q   <= 1'b0;
            e_ack_q   <= 1'b0;
            half_q    <= 1'b0;
            tag_q     <= '0;
            wait_cnt  <= '0;
        end else begin
            i_valid_q <= bus.mem_i_rd_i;
            d_ack_q   <= data_fire;
            e_ack_q   <= ext_grant;
            if (data_fire)
                tag_q <= bus.mem_d_req_tag_i;
            if (data_fire || ext_grant)
                half_q <= sh_half;
            if (!ext_req || ext_grant)
                wait_cnt <= '0;
            else if (wait_cnt != MAX_WAIT)
                wait_cnt <= wait_cnt + 4'd1;
        end
    end

    assign rd_half = half_q ? sh_rdata_q[63:32] : sh_rdata_q[31:0];

    // Responses registered before a reset must not leak out while reset is held.
    assign bus.mem_i_valid_o    = i_valid_q & ~rst_i;
    assign bus.mem_i_inst_o     = inst_q;
    assign bus.mem_d_accept_o   = data_grant;
    assign bus.mem_d_ack_o      = d_ack_q & ~rst_i;
    assign bus.mem_d_data_rd_o  = rd_half;
    assign bus.mem_d_resp_tag_o = rst_i ? 11'd0 : tag_q;
    assign bus.ext_accept_o     = ext_grant;
    assign bus.ext_ack_o        = e_ack_q & ~rst_i;
    assign bus.ext_data_rd_o    = rd_half;

`ifdef TCM_MEM_PARITY_EN
    logic [7:0] par_ram [WORDS];
    logic [7:0] inst_par_q, sh_par_q, sh_bad_bytes;
    logic       inst_bad, sh_bad;

    function automatic logic [7:0] byte_par(input logic [63:0] w);
        logic [7:0] p;
        for (int i = 0; i < 8; i++)
            p[i] = ^w[8*i +: 8];
        return p;
    endfunction

    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 4; b++) begin
            if (sh_be[b]) begin
                if (sh_half) par_ram[sh_idx][4 + b] <= ^sh_wdata[8*b +: 8];
                else         par_ram[sh_idx][b]     <= ^sh_wdata[8*b +: 8];
            end
        end
        if (bus.mem_i_rd_i)
            inst_par_q <= par_ram[i_idx];
        if (data_fire || ext_grant)
            sh_par_q <= par_ram[sh_idx];
    end

    assign inst_bad     = |(byte_par(inst_q) ^ inst_par_q);
    assign sh_bad_bytes = byte_par(sh_rdata_q) ^ sh_par_q;
    assign sh_bad       = half_q ? (|sh_bad_bytes[7:4]) : (|sh_bad_bytes[3:0]);

    assign bus.mem_i_error_o = bus.mem_i_valid_o & inst_bad;
    assign bus.mem_d_error_o = bus.mem_d_ack_o & sh_bad;
    assign bus.ext_error_o   = bus.ext_ack_o & sh_bad;
`else
    assign bus.mem_i_error_o = 1'b0;
    assign bus.mem_d_error_o = 1'b0;
    assign bus.ext_error_o   = 1'b0;
`endif

    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.mem_i_pc_i[31:AW+3], bus.mem_i_pc_i[2:0],
                                sh_addr[31:AW+3], sh_addr[1:0]};
endmodule

// File: tb/tb_tcm_mem_arb.sv
// tb/tb_tcm_mem_arb.sv - self-checking bench for tcm_mem_arb
// Define TCM_MEM_PARITY_EN for both RTL and bench to include the parity scenario.
module tb_tcm_mem_arb;
    localparam int MAXW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tcm_mem_arb_if bus();

    tcm_mem_arb #(.TCM_MEM_DEPTH(16), .EXT_MAX_WAIT(MAXW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    logic [63:0] model [32];

    task automatic idle();
        bus.mem_i_rd_i      = 1'b0;
        bus.mem_i_pc_i      = '0;
        bus.mem_d_addr_i    = '0;
        bus.mem_d_data_wr_i = '0;
        bus.mem_d_rd_i      = 1'b0;
        bus.mem_d_wr_i      = '0;
        bus.mem_d_cmo_i     = 1'b0;
        bus.mem_d_req_tag_i = '0;
        bus.ext_rd_i        = 1'b0;
        bus.ext_wr_i        = '0;
        bus.ext_addr_i      = '0;
        bus.ext_data_wr_i   = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        bus.mem_d_rd_i = 1'b1; bus.ext_rd_i = 1'b1; bus.mem_i_rd_i = 1'b1;
        bus.mem_d_req_tag_i = 11'h7FF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.ext_accept_o !== 1'b0) begin failures++; $display("FAIL reset_ext_accept got=%b exp=0", bus.ext_accept_o); end
        checks++; if (bus.mem_d_accept_o !== 1'b0) begin failures++; $display("FAIL reset_d_accept got=%b exp=0", bus.mem_d_accept_o); end
        checks++; if (bus.mem_i_valid_o !== 1'b0) begin failures++; $display("FAIL reset_i_valid got=%b exp=0", bus.mem_i_valid_o); end
        checks++; if ({bus.mem_d_ack_o, bus.ext_ack_o} !== 2'b00) begin failures++; $display("FAIL reset_acks got=%b exp=00", {bus.mem_d_ack_o, bus.ext_ack_o}); end
        checks++; if (bus.mem_d_resp_tag_o !== 11'd0) begin failures++; $display("FAIL reset_tag got=%h exp=0", bus.mem_d_resp_tag_o); end
        checks++; if ({bus.mem_i_error_o, bus.mem_d_error_o, bus.ext_error_o} !== 3'b000) begin failures++; $display("FAIL reset_errors got=%b exp=000", {bus.mem_i_error_o, bus.mem_d_error_o, bus.ext_error_o}); end
        @(posedge clk); #1;
        rst = 1'b0;
        idle();
        @(negedge clk);
        checks++; if ({bus.mem_d_ack_o, bus.ext_ack_o, bus.mem_i_valid_o} !== 3'b000) begin failures++; $display("FAIL post_reset_idle got=%b exp=000", {bus.mem_d_ack_o, bus.ext_ack_o, bus.mem_i_valid_o}); end
    endtask

    task automatic test_directed();
        @(posedge clk); #1;
        bus.mem_d_wr_i = 4'hF; bus.mem_d_addr_i = 32'h104; bus.mem_d_data_wr_i = 32'hDEADBEEF; bus.mem_d_req_tag_i = 11'h011;
        @(negedge clk);
        checks++; if (bus.mem_d_accept_o !== 1'b1) begin failures++; $display("FAIL wr_accept got=%b exp=1", bus.mem_d_accept_o); end
        @(posedge clk); #1;
        bus.mem_d_wr_i = 4'h0; bus.mem_d_rd_i = 1'b1; bus.mem_d_req_tag_i = 11'h2A5;
        @(negedge clk);
        checks++; if (bus.mem_d_ack_o !== 1'b1 || bus.mem_d_resp_tag_o !== 11'h011) begin failures++; $display("FAIL wr_ack got=%b/%h exp=1/011", bus.mem_d_ack_o, bus.mem_d_resp_tag_o); end
        @(posedge clk); #1;
        idle();
        bus.mem_i_rd_i = 1'b1; bus.mem_i_pc_i = 32'h100;
        @(negedge clk);
        checks++; if (bus.mem_d_ack_o !== 1'b1 || bus.mem_d_data_rd_o !== 32'hDEADBEEF || bus.mem_d_resp_tag_o !== 11'h2A5) begin failures++; $display("FAIL rd_word got=%b/%h/%h exp=1/deadbeef/2a5", bus.mem_d_ack_o, bus.mem_d_data_rd_o, bus.mem_d_resp_tag_o); end
        @(posedge clk); #1;
        idle();
        @(negedge clk);
        checks++; if (bus.mem_i_valid_o !== 1'b1 || bus.mem_i_inst_o[63:32] !== 32'hDEADBEEF) begin failures++; $display("FAIL fetch_word got=%b/%h exp=1/deadbeef", bus.mem_i_valid_o, bus.mem_i_inst_o[63:32]); end
        checks++; if (bus.mem_d_ack_o !== 1'b0) begin failures++; $display("FAIL idle_no_ack got=%b exp=0", bus.mem_d_ack_o); end

        @(posedge clk); #1;
        bus.mem_d_wr_i = 4'hF; bus.mem_d_addr_i = 32'h108; bus.mem_d_data_wr_i = 32'h11223344;
        @(posedge clk); #1;
        bus.mem_d_wr_i = 4'b0010; bus.mem_d_data_wr_i = 32'h0000AB00;
        @(posedge clk); #1;
        bus.mem_d_wr_i = 4'h0; bus.mem_d_cmo_i = 1'b1; bus.mem_d_req_tag_i = 11'h4C3; bus.mem_d_data_wr_i = 32'hFFFFFFFF;
        @(negedge clk);
        checks++; if (bus.mem_d_accept_o !== 1'b1) begin failures++; $display("FAIL cmo_accept got=%b exp=1", bus.mem_d_accept_o); end
        @(posedge clk); #1;
        bus.mem_d_cmo_i = 1'b0; bus.mem_d_rd_i = 1'b1; bus.mem_d_req_tag_i = 11'h001;
        @(negedge clk);
        checks++; if (bus.mem_d_ack_o !== 1'b1 || bus.mem_d_resp_tag_o !== 11'h4C3) begin failures++; $display("FAIL cmo_ack got=%b/%h exp=1/4c3", bus.mem_d_ack_o, bus.mem_d_resp_tag_o); end
        @(posedge clk); #1;
        idle();
        @(negedge clk);
        checks++; if (bus.mem_d_data_rd_o !== 32'h1122AB44) begin failures++; $display("FAIL byte_write got=%h exp=1122ab44", bus.mem_d_data_rd_o); end
    endtask

    task automatic test_arbitration();
        int grant_cycle = 0;
        @(posedge clk); #1;
        bus.mem_d_rd_i = 1'b1; bus.mem_d_addr_i = 32'h10;
        bus.ext_rd_i = 1'b1; bus.ext_addr_i = 32'h104;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (bus.ext_accept_o === 1'b1) begin
                grant_cycle = c;
                checks++; if (bus.mem_d_accept_o !== 1'b0) begin failures++; $display("FAIL arb_d_blocked got=%b exp=0", bus.mem_d_accept_o); end
                break;
            end
            checks++; if (bus.mem_d_accept_o !== 1'b1) begin failures++; $display("FAIL arb_d_wins cycle=%0d got=%b exp=1", c, bus.mem_d_accept_o); end
            @(posedge clk); #1;
        end
        checks++; if (grant_cycle != MAXW + 1) begin failures++; $display("FAIL arb_grant_cycle got=%0d exp=%0d", grant_cycle, MAXW + 1); end
        @(posedge clk); #1;
        bus.ext_rd_i = 1'b0;
        @(negedge clk);
        checks++; if (bus.ext_ack_o !== 1'b1 || bus.mem_d_ack_o !== 1'b0 || bus.ext_data_rd_o !== 32'hDEADBEEF) begin failures++; $display("FAIL arb_ext_ack got=%b/%b/%h exp=1/0/deadbeef", bus.ext_ack_o, bus.mem_d_ack_o, bus.ext_data_rd_o); end
        @(posedge clk); #1;
        idle();
    endtask

    task automatic init_mem();
        for (int i = 0; i < 32; i++) begin
            for (int h = 0; h < 2; h++) begin
                logic [31:0] d;
                d = $urandom;
                @(posedge clk); #1;
                bus.mem_d_wr_i = 4'hF;
                bus.mem_d_addr_i = 32'(i * 8 + h * 4);
                bus.mem_d_data_wr_i = d;
                model[i][h*32 +: 32] = d;
            end
        end
        @(posedge clk); #1;
        idle();
    endtask

    task automatic test_random();
        int   stall = 0;
        logic pend_d = 1'b0, pend_d_rd = 1'b0, pend_e = 1'b0, pend_e_rd = 1'b0, pend_i = 1'b0;
        logic [10:0] pend_tag = '0;
        logic [31:0] pend_d_data = '0, pend_e_data = '0;
        logic [63:0] pend_inst = '0;
        init_mem();
        for (int n = 0; n < 500; n++) begin
            int dk, ek, di, dh, ei, eh, ii;
            logic ik, d_req, e_req, e_win;
            @(posedge clk); #1;
            dk = $urandom_range(0, 3); ek = $urandom_range(0, 2); ik = 1'($urandom_range(0, 1));
            di = $urandom_range(0, 31); dh = $urandom_range(0, 1);
            ei = $urandom_range(0, 31); eh = $urandom_range(0, 1);
            ii = $urandom_range(0, 31);
            bus.mem_d_rd_i      = (dk == 1);
            bus.mem_d_wr_i      = (dk == 2) ? 4'($urandom_range(1, 15)) : 4'h0;
            bus.mem_d_cmo_i     = (dk == 3);
            bus.mem_d_addr_i    = ($urandom & 32'hFFFFC000) | 32'(di * 8 + dh * 4) | 32'($urandom_range(0, 3));
            bus.mem_d_data_wr_i = $urandom;
            bus.mem_d_req_tag_i = 11'($urandom);
            bus.ext_rd_i        = (ek == 1);
            bus.ext_wr_i        = (ek == 2) ? 4'($urandom_range(1, 15)) : 4'h0;
            bus.ext_addr_i      = ($urandom & 32'hFFFFC000) | 32'(ei * 8 + eh * 4);
            bus.ext_data_wr_i   = $urandom;
            bus.mem_i_rd_i      = ik;
            bus.mem_i_pc_i      = ($urandom & 32'hFFFFC007) | 32'(ii * 8);
            @(negedge clk);
            checks++; if (bus.mem_d_ack_o !== pend_d) begin failures++; $display("FAIL rnd_d_ack n=%0d got=%b exp=%b", n, bus.mem_d_ack_o, pend_d); end
            if (pend_d) begin
                checks++; if (bus.mem_d_resp_tag_o !== pend_tag) begin failures++; $display("FAIL rnd_d_tag n=%0d got=%h exp=%h", n, bus.mem_d_resp_tag_o, pend_tag); end
            end
            if (pend_d && pend_d_rd) begin
                checks++; if (bus.mem_d_data_rd_o !== pend_d_data) begin failures++; $display("FAIL rnd_d_data n=%0d got=%h exp=%h", n, bus.mem_d_data_rd_o, pend_d_data); end
            end
            checks++; if (bus.ext_ack_o !== pend_e) begin failures++; $display("FAIL rnd_e_ack n=%0d got=%b exp=%b", n, bus.ext_ack_o, pend_e); end
            if (pend_e && pend_e_rd) begin
                checks++; if (bus.ext_data_rd_o !== pend_e_data) begin failures++; $display("FAIL rnd_e_data n=%0d got=%h exp=%h", n, bus.ext_data_rd_o, pend_e_data); end
            end
            checks++; if (bus.mem_i_valid_o !== pend_i) begin failures++; $display("FAIL rnd_i_valid n=%0d got=%b exp=%b", n, bus.mem_i_valid_o, pend_i); end
            if (pend_i) begin
                checks++; if (bus.mem_i_inst_o !== pend_inst) begin failures++; $display("FAIL rnd_inst n=%0d got=%h exp=%h", n, bus.mem_i_inst_o, pend_inst); end
            end
            checks++; if ({bus.mem_i_error_o, bus.mem_d_error_o, bus.ext_error_o} !== 3'b000) begin failures++; $display("FAIL rnd_errors n=%0d got=%b exp=000", n, {bus.mem_i_error_o, bus.mem_d_error_o, bus.ext_error_o}); end

            // External side gets the port once it has waited MAXW stalled cycles.
            d_req = (dk != 0);
            e_req = (ek != 0);
            e_win = e_req && (!d_req || stall >= MAXW);
            checks++; if (bus.ext_accept_o !== e_win || bus.mem_d_accept_o !== !e_win) begin failures++; $display("FAIL rnd_accept n=%0d got=%b%b exp=%b%b", n, bus.ext_accept_o, bus.mem_d_accept_o, e_win, !e_win); end

            pend_d      = d_req && !e_win;
            pend_d_rd   = (dk == 1);
            pend_tag    = bus.mem_d_req_tag_i;
            pend_d_data = model[di][dh*32 +: 32];
            pend_e      = e_win;
            pend_e_rd   = (ek == 1);
            pend_e_data = model[ei][eh*32 +: 32];
            pend_i      = ik;
            pend_inst   = model[ii];
            for (int b = 0; b < 4; b++) begin
                if (pend_d && dk == 2 && bus.mem_d_wr_i[b])
                    model[di][dh*32 + b*8 +: 8] = bus.mem_d_data_wr_i[b*8 +: 8];
                if (e_win && ek == 2 && bus.ext_wr_i[b])
                    model[ei][eh*32 + b*8 +: 8] = bus.ext_data_wr_i[b*8 +: 8];
            end
            if (!e_req || e_win) stall = 0;
            else if (stall < MAXW) stall++;
        end
        @(posedge clk); #1;
        idle();
        @(negedge clk);
        checks++; if (bus.mem_d_ack_o !== pend_d || bus.ext_ack_o !== pend_e) begin failures++; $display("FAIL rnd_last_ack got=%b%b exp=%b%b", bus.mem_d_ack_o, bus.ext_ack_o, pend_d, pend_e); end
    endtask

    task automatic test_alias_reset();
        @(posedge clk); #1;
        idle();
        bus.mem_d_wr_i = 4'hF; bus.mem_d_addr_i = 32'h4000; bus.mem_d_data_wr_i = 32'hCAFEF00D;
        @(posedge clk); #1;
        bus.mem_d_wr_i = 4'h0; bus.mem_d_rd_i = 1'b1; bus.mem_d_addr_i = 32'h0; bus.mem_d_req_tag_i = 11'h03C;
        @(posedge clk); #1;
        idle();
        @(negedge clk);
        checks++; if (bus.mem_d_data_rd_o !== 32'hCAFEF00D || bus.mem_d_resp_tag_o !== 11'h03C) begin failures++; $display("FAIL alias got=%h/%h exp=cafef00d/03c", bus.mem_d_data_rd_o, bus.mem_d_resp_tag_o); end
        @(posedge clk); #1;
        bus.mem_d_rd_i = 1'b1; bus.mem_d_req_tag_i = 11'h055; bus.mem_i_rd_i = 1'b1;
        @(negedge clk);
        checks++; if (bus.mem_d_accept_o !== 1'b1) begin failures++; $display("FAIL pre_reset_accept got=%b exp=1", bus.mem_d_accept_o); end
        @(posedge clk); #1;
        rst = 1'b1;
        idle();
        @(negedge clk);
        checks++; if ({bus.mem_d_ack_o, bus.mem_i_valid_o, bus.ext_ack_o} !== 3'b000 || bus.mem_d_resp_tag_o !== 11'd0) begin failures++; $display("FAIL reset_kill got=%b/%h exp=000/000", {bus.mem_d_ack_o, bus.mem_i_valid_o, bus.ext_ack_o}, bus.mem_d_resp_tag_o); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if ({bus.mem_d_ack_o, bus.mem_i_valid_o} !== 2'b00) begin failures++; $display("FAIL reset_no_late_ack got=%b exp=00", {bus.mem_d_ack_o, bus.mem_i_valid_o}); end
    endtask

`ifdef TCM_MEM_PARITY_EN
    task automatic test_parity();
        @(posedge clk); #1;
        idle();
        bus.mem_d_wr_i = 4'hF; bus.mem_d_addr_i = 32'h200; bus.mem_d_data_wr_i = 32'hA5A51234;
        @(posedge clk); #1;
        bus.mem_d_wr_i = 4'h0; bus.mem_d_rd_i = 1'b1;
        @(posedge clk); #1;
        idle();
        @(negedge clk);
        checks++; if (bus.mem_d_ack_o !== 1'b1 || bus.mem_d_error_o !== 1'b0) begin failures++; $display("FAIL parity_clean got=%b/%b exp=1/0", bus.mem_d_ack_o, bus.mem_d_error_o); end
        dut.ram[64][9] = ~dut.ram[64][9];
        @(posedge clk); #1;
        bus.mem_d_rd_i = 1'b1; bus.mem_d_addr_i = 32'h200;
        @(posedge clk); #1;
        idle();
        @(negedge clk);
        checks++; if (bus.mem_d_ack_o !== 1'b1 || bus.mem_d_error_o !== 1'b1) begin failures++; $display("FAIL parity_flip got=%b/%b exp=1/1", bus.mem_d_ack_o, bus.mem_d_error_o); end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        test_reset();
        test_directed();
        test_arbitration();
        test_random();
        test_alias_reset();
`ifdef TCM_MEM_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
